// File: rtl/multu_hilo.sv
// multu_hilo: sequential 32-iteration unsigned shift-add multiplier committing into HI/LO
module multu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       sel,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] dataOut
);
    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] OUT   = 6'h3f;
    localparam logic [5:0] MFHI  = 6'd16;
    localparam logic [5:0] MFLO  = 6'd18;
    typedef enum logic [1:0] {IDLE, RUN, WAIT_OUT} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [5:0]         count;
    logic [WIDTH:0]     sum;
    logic               keep;
    assign keep = sel == MULTU || sel == OUT;
    // one extra bit keeps the adder carry, which shifts back into the product
    assign sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{prod[0]}} & mcand};
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state == IDLE ? (sel == MULTU ? RUN : IDLE)
                 : state == RUN  ? (!keep ? IDLE : count == 6'(WIDTH - 1) ? WAIT_OUT : RUN)
                 : (state == WAIT_OUT && sel == MULTU) ? WAIT_OUT : IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mcand <= '0;
            prod  <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (state == IDLE && sel == MULTU) begin
                mcand <= dataA;
                prod  <= {{WIDTH{1'b0}}, dataB};
                count <= '0;
            end else if (state == RUN && keep) begin
                prod  <= {sum, prod[WIDTH-1:1]};
                count <= count + 6'd1;
            end
            if (state == WAIT_OUT && sel == OUT) begin
                hi <= prod[2*WIDTH-1:WIDTH];
                lo <= prod[WIDTH-1:0];
            end
        end
    always_comb begin
        busy    = state == RUN;
        done    = state == WAIT_OUT;
        dataOut = sel == MFHI ? hi : sel == MFLO ? lo : '0;
    end
endmodule

// File: tb/tb_multu_hilo.sv
// tb_multu_hilo: random and directed checks of multu_hilo against a product-level model
module tb_multu_hilo;
    logic        clk = 0, reset = 1;
    logic [5:0]  sel = 6'd16;
    logic [31:0] dataA = 0, dataB = 0;
    logic        busy, done;
    logic [31:0] hi, lo, dataOut;
    int vectors = 0, miscompares = 0, busy_cnt = 0;
    int          m_left = 0;
    bit          m_ready = 0;
    logic [63:0] m_pend = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    multu_hilo dut (.clk(clk), .reset(reset), .sel(sel), .dataA(dataA), .dataB(dataB),
                    .busy(busy), .done(done), .hi(hi), .lo(lo), .dataOut(dataOut));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a start captures a*b; 32 kept edges later it is ready; OUT commits it.
    always @(posedge clk or posedge reset)
        if (reset) begin
            m_left <= 0; m_ready <= 0; m_hi <= 0; m_lo <= 0;
        end else if (m_left > 0) begin
            if (sel == 6'd25 || sel == 6'd63) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_ready <= 1;
            end else m_left <= 0;
        end else if (m_ready) begin
            if (sel == 6'd63) begin m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0]; end
            if (sel != 6'd25) m_ready <= 0;
        end else if (sel == 6'd25) begin
            m_pend <= 64'(dataA) * 64'(dataB);
            m_left <= 32;
        end

    always @(negedge clk) begin
        chk("busy", busy, m_left > 0);
        chk("done", done, m_ready);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("dataOut", dataOut, sel == 6'd16 ? m_hi : sel == 6'd18 ? m_lo : 32'd0);
        if (busy) busy_cnt++;
    end

    task automatic cyc(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #1;
        sel = s; dataA = a; dataB = b;
    endtask

    task automatic mult(input logic [31:0] a, input logic [31:0] b);
        repeat (33) cyc(6'd25, a, b);
        cyc(6'd63, a, b);
        cyc(6'd0, 0, 0);
    endtask

    logic [5:0] pick [4] = '{6'd63, 6'd16, 6'd18, 6'd25};

    initial begin
        #1;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_dout", dataOut, 0);
        repeat (2) @(negedge clk);
        #1 reset = 0;
        busy_cnt = 0;
        mult(3, 5);
        chk("3x5_busy_cycles", busy_cnt, 32);
        chk("3x5_hi", hi, 0); chk("3x5_lo", lo, 15);
        mult(32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("max_hi", hi, 32'hFFFFFFFE); chk("max_lo", lo, 32'h00000001);
        mult(7, 9);
        chk("7x9_lo", lo, 63);
        repeat (11) cyc(6'd25, 32'h10000, 32'h10000);
        cyc(6'd32, 0, 0);
        cyc(6'd0, 0, 0);
        chk("abort_busy", busy, 0); chk("abort_hi", hi, 0); chk("abort_lo", lo, 63);
        mult(2, 2);
        chk("2x2_lo", lo, 4);
        repeat (16) cyc(6'd25, 32'h1234, 32'h5678);
        #2 reset = 1;
        #1;
        chk("rstrun_busy", busy, 0); chk("rstrun_done", done, 0);
        chk("rstrun_hi", hi, 0); chk("rstrun_lo", lo, 0);
        cyc(6'd0, 0, 0);
        reset = 0;
        mult(3, 7);
        chk("after_rst_lo", lo, 21);
        mult(32'h80000000, 4);
        cyc(6'd16, 0, 0); #1 chk("mfhi", dataOut, 2);
        cyc(6'd18, 0, 0); #1 chk("mflo", dataOut, 0);
        cyc(6'd42, 0, 0); #1 chk("slt", dataOut, 0);
        cyc(6'd25, 6, 7);
        repeat (42) cyc(6'd25, $urandom, $urandom);
        chk("hold_done", done, 1); chk("hold_hi", hi, 2); chk("hold_lo", lo, 0);
        cyc(6'd63, 0, 0);
        cyc(6'd0, 0, 0);
        chk("hold_res_hi", hi, 0); chk("hold_res_lo", lo, 42);
        for (int t = 0; t < 40; t++) begin
            int hold;
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if (t % 4 == 0) a = a >> $urandom_range(31, 0);
            hold = ($urandom_range(3, 0) == 0) ? $urandom_range(32, 1) : 33 + $urandom_range(3, 0);
            cyc(6'd25, a, b);
            for (int k = 1; k < hold; k++)
                cyc($urandom_range(5, 0) == 0 ? 6'd63 : 6'd25, $urandom, $urandom);
            cyc($urandom_range(3, 0) == 0 ? 6'($urandom_range(63, 0)) : pick[$urandom_range(2, 0)], 0, 0);
            repeat (2) cyc($urandom_range(2, 0) == 0 ? 6'($urandom_range(63, 0)) : pick[$urandom_range(2, 1)], 0, 0);
        end
        cyc(6'd0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
